// File: rtl/reorder_buffer_if.sv
//------------------------------------------------------------------------------
// Module      : reorder_buffer_if
// Description : Dispatch, writeback, operand-lookup and commit signals of the
//               reorder buffer, with modports for the buffer and its driver.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface reorder_buffer_if #(
    parameter int ROB_SIZE     = 16,
    parameter int ROB_SIZE_LOG = $clog2(ROB_SIZE + 1)
);
    logic                    allocValid_i;
    logic [3:0]              allocCmdType_i;
    logic [4:0]              allocRD_i;
    logic [63:0]             allocData_i;
    logic [ROB_SIZE_LOG-1:0] allocTag_o;
    logic                    full_o;

    logic                    wbValidA_i;
    logic [ROB_SIZE_LOG-1:0] wbTagA_i;
    logic [63:0]             wbDataA_i;
    logic                    wbFlagValidA_i;
    logic [3:0]              wbFlagsA_i;
    logic                    wbValidB_i;
    logic [ROB_SIZE_LOG-1:0] wbTagB_i;
    logic [63:0]             wbDataB_i;

    logic [ROB_SIZE_LOG-1:0] readTag_i;
    logic [63:0]             readData_o;
    logic                    readReady_o;

    logic [ROB_SIZE_LOG-1:0] ROBhead_o;
    logic [78:0]             ROBcommitReadData_o;
    logic                    ROBupdateHead_i;
    logic                    flush_i;

    modport master (
        output allocValid_i, allocCmdType_i, allocRD_i, allocData_i,
        output wbValidA_i, wbTagA_i, wbDataA_i, wbFlagValidA_i, wbFlagsA_i,
        output wbValidB_i, wbTagB_i, wbDataB_i,
        output readTag_i, ROBupdateHead_i, flush_i,
        input  allocTag_o, full_o, readData_o, readReady_o,
        input  ROBhead_o, ROBcommitReadData_o
    );

    modport slave (
        input  allocValid_i, allocCmdType_i, allocRD_i, allocData_i,
        input  wbValidA_i, wbTagA_i, wbDataA_i, wbFlagValidA_i, wbFlagsA_i,
        input  wbValidB_i, wbTagB_i, wbDataB_i,
        input  readTag_i, ROBupdateHead_i, flush_i,
        output allocTag_o, full_o, readData_o, readReady_o,
        output ROBhead_o, ROBcommitReadData_o
    );
endinterface

`default_nettype wire

// File: rtl/reorder_buffer.sv
//------------------------------------------------------------------------------
// Module      : reorder_buffer
// Description : Circular reorder buffer; in-order allocate, out-of-order
//               writeback from ALU/LSQ ports, in-order retire, full flush.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reorder_buffer #(
    parameter int ROB_SIZE     = 16,
    parameter int ROB_SIZE_LOG = $clog2(ROB_SIZE + 1)
) (
    input  wire logic       clk_i,
    input  wire logic       reset_i,
    reorder_buffer_if.slave bus
);

    localparam logic [ROB_SIZE_LOG-1:0] C_TAG_FIRST = ROB_SIZE_LOG'(1);
    localparam logic [ROB_SIZE_LOG-1:0] C_TAG_LAST  = ROB_SIZE_LOG'(ROB_SIZE);

    // Entry 0 exists only so a full-width tag indexes the arrays; it is never written.
    logic                    occ_q   [0:ROB_SIZE];
    logic                    occ_d   [0:ROB_SIZE];
    logic                    done_q  [0:ROB_SIZE];
    logic                    done_d  [0:ROB_SIZE];
    logic                    fv_q    [0:ROB_SIZE];
    logic                    fv_d    [0:ROB_SIZE];
    logic [3:0]              flags_q [0:ROB_SIZE];
    logic [3:0]              flags_d [0:ROB_SIZE];
    logic [3:0]              cmd_q   [0:ROB_SIZE];
    logic [3:0]              cmd_d   [0:ROB_SIZE];
    logic [4:0]              rd_q    [0:ROB_SIZE];
    logic [4:0]              rd_d    [0:ROB_SIZE];
    logic [63:0]             data_q  [0:ROB_SIZE];
    logic [63:0]             data_d  [0:ROB_SIZE];

    logic [ROB_SIZE_LOG-1:0] head_q, head_d;
    logic [ROB_SIZE_LOG-1:0] tail_q, tail_d;
    logic [ROB_SIZE_LOG-1:0] count_q, count_d;

    logic w_full;
    logic w_head_ready;
    logic w_alloc;
    logic w_retire;
    logic w_wb_a;
    logic w_wb_b;
    logic w_read_ready;

    function automatic logic [ROB_SIZE_LOG-1:0] tag_inc(input logic [ROB_SIZE_LOG-1:0] tag);
        return (tag == C_TAG_LAST) ? C_TAG_FIRST : tag + 1'b1;
    endfunction

    function automatic logic tag_ok(input logic [ROB_SIZE_LOG-1:0] tag);
        return (tag != '0) && (tag <= C_TAG_LAST);
    endfunction

    assign w_full       = (count_q == C_TAG_LAST);
    assign w_head_ready = occ_q[head_q] && done_q[head_q];
    assign w_alloc      = bus.allocValid_i && !w_full && !bus.flush_i;
    assign w_retire     = bus.ROBupdateHead_i && w_head_ready;
    assign w_wb_a       = bus.wbValidA_i && tag_ok(bus.wbTagA_i) && occ_q[bus.wbTagA_i];
    assign w_wb_b       = bus.wbValidB_i && tag_ok(bus.wbTagB_i) && occ_q[bus.wbTagB_i];
    assign w_read_ready = tag_ok(bus.readTag_i) && occ_q[bus.readTag_i] && done_q[bus.readTag_i];

    always_comb begin
        for (int i = 0; i <= ROB_SIZE; i++) begin
            occ_d[i]   = occ_q[i];
            done_d[i]  = done_q[i];
            fv_d[i]    = fv_q[i];
            flags_d[i] = flags_q[i];
            cmd_d[i]   = cmd_q[i];
            rd_d[i]    = rd_q[i];
            data_d[i]  = data_q[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (bus.flush_i) begin
            for (int i = 0; i <= ROB_SIZE; i++) begin
                occ_d[i]  = 1'b0;
                done_d[i] = 1'b0;
                fv_d[i]   = 1'b0;
            end
            head_d  = C_TAG_FIRST;
            tail_d  = C_TAG_FIRST;
            count_d = '0;
        end else begin
            // Port B first so that port A overrides it on a shared tag.
            if (w_wb_b) begin
                done_d[bus.wbTagB_i] = 1'b1;
                data_d[bus.wbTagB_i] = bus.wbDataB_i;
            end
            if (w_wb_a) begin
                done_d[bus.wbTagA_i]  = 1'b1;
                data_d[bus.wbTagA_i]  = bus.wbDataA_i;
                fv_d[bus.wbTagA_i]    = bus.wbFlagValidA_i;
                flags_d[bus.wbTagA_i] = bus.wbFlagsA_i;
            end
            if (w_retire) begin
                occ_d[head_q]  = 1'b0;
                done_d[head_q] = 1'b0;
                fv_d[head_q]   = 1'b0;
                head_d         = tag_inc(head_q);
            end
            if (w_alloc) begin
                occ_d[tail_q]   = 1'b1;
                done_d[tail_q]  = 1'b0;
                fv_d[tail_q]    = 1'b0;
                flags_d[tail_q] = 4'd0;
                cmd_d[tail_q]   = bus.allocCmdType_i;
                rd_d[tail_q]    = bus.allocRD_i;
                data_d[tail_q]  = bus.allocData_i;
                tail_d          = tag_inc(tail_q);
            end
            case ({w_alloc, w_retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i <= ROB_SIZE; i++) begin
                occ_q[i]   <= 1'b0;
                done_q[i]  <= 1'b0;
                fv_q[i]    <= 1'b0;
                flags_q[i] <= 4'd0;
                cmd_q[i]   <= 4'd0;
                rd_q[i]    <= 5'd0;
                data_q[i]  <= 64'd0;
            end
            head_q  <= C_TAG_FIRST;
            tail_q  <= C_TAG_FIRST;
            count_q <= '0;
        end else begin
            for (int i = 0; i <= ROB_SIZE; i++) begin
                occ_q[i]   <= occ_d[i];
                done_q[i]  <= done_d[i];
                fv_q[i]    <= fv_d[i];
                flags_q[i] <= flags_d[i];
                cmd_q[i]   <= cmd_d[i];
                rd_q[i]    <= rd_d[i];
                data_q[i]  <= data_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign bus.allocTag_o  = tail_q;
    assign bus.full_o      = w_full;
    assign bus.ROBhead_o   = head_q;
    assign bus.readReady_o = w_read_ready;
    assign bus.readData_o  = w_read_ready ? data_q[bus.readTag_i] : 64'd0;

    assign bus.ROBcommitReadData_o = occ_q[head_q]
        ? {cmd_q[head_q], rd_q[head_q], fv_q[head_q], flags_q[head_q], w_head_ready, data_q[head_q]}
        : 79'd0;

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
//------------------------------------------------------------------------------
// Module      : tb_reorder_buffer
// Description : Directed and randomized bench for reorder_buffer against a
//               queue-based program-order model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reorder_buffer;
    localparam int N  = 16;
    localparam int TW = $clog2(N + 1);

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk_i = ~clk_i;

    reorder_buffer_if #(.ROB_SIZE(N)) bus ();
    reorder_buffer #(.ROB_SIZE(N)) dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));

    typedef struct {
        int          tag;
        logic [3:0]  cmd;
        logic [4:0]  rd;
        logic [63:0] data;
        bit          done;
        bit          fv;
        logic [3:0]  flags;
    } ent_t;

    // In-flight instructions, oldest first; tail is the next tag to hand out.
    ent_t rob[$];
    int   tail = 1;

    function automatic int nxt(int t);
        return (t == N) ? 1 : t + 1;
    endfunction

    function automatic int find(int t);
        foreach (rob[i]) if (rob[i].tag == t) return i;
        return -1;
    endfunction

    function automatic logic [TW-1:0] pick_tag();
        if (rob.size() > 0 && $urandom_range(0, 3) != 0)
            return TW'(rob[$urandom_range(0, rob.size() - 1)].tag);
        return TW'($urandom_range(0, N));
    endfunction

    task automatic chk(input string name, input logic [78:0] act, input logic [78:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    endtask

    task automatic check_all();
        logic [78:0] cw;
        logic        rdy;
        logic [63:0] rdat;
        int          idx;
        cw   = '0;
        rdy  = 1'b0;
        rdat = '0;
        if (rob.size() > 0)
            cw = {rob[0].cmd, rob[0].rd, rob[0].fv, rob[0].flags, rob[0].done, rob[0].data};
        idx = find(int'(bus.readTag_i));
        if (idx >= 0 && rob[idx].done) begin
            rdy  = 1'b1;
            rdat = rob[idx].data;
        end
        chk("allocTag", 79'(bus.allocTag_o), 79'(tail));
        chk("full", 79'(bus.full_o), 79'(rob.size() == N));
        chk("head", 79'(bus.ROBhead_o), 79'((rob.size() > 0) ? rob[0].tag : tail));
        chk("commit", bus.ROBcommitReadData_o, cw);
        chk("readReady", 79'(bus.readReady_o), 79'(rdy));
        chk("readData", 79'(bus.readData_o), 79'(rdat));
    endtask

    task automatic model_step();
        bit ret;
        bit alc;
        int ia;
        int ib;
        if (bus.flush_i) begin
            rob.delete();
            tail = 1;
            return;
        end
        ret = bus.ROBupdateHead_i && rob.size() > 0 && rob[0].done;
        alc = bus.allocValid_i && rob.size() < N;
        if (bus.wbValidB_i) begin
            ib = find(int'(bus.wbTagB_i));
            if (ib >= 0) begin
                rob[ib].done = 1'b1;
                rob[ib].data = bus.wbDataB_i;
            end
        end
        if (bus.wbValidA_i) begin
            ia = find(int'(bus.wbTagA_i));
            if (ia >= 0) begin
                rob[ia].done  = 1'b1;
                rob[ia].data  = bus.wbDataA_i;
                rob[ia].fv    = bus.wbFlagValidA_i;
                rob[ia].flags = bus.wbFlagsA_i;
            end
        end
        if (ret) void'(rob.pop_front());
        if (alc) begin
            ent_t e;
            e.tag   = tail;
            e.cmd   = bus.allocCmdType_i;
            e.rd    = bus.allocRD_i;
            e.data  = bus.allocData_i;
            e.done  = 1'b0;
            e.fv    = 1'b0;
            e.flags = 4'd0;
            rob.push_back(e);
            tail = nxt(tail);
        end
    endtask

    task automatic idle();
        bus.allocValid_i    = 1'b0;
        bus.allocCmdType_i  = 4'd0;
        bus.allocRD_i       = 5'd0;
        bus.allocData_i     = 64'd0;
        bus.wbValidA_i      = 1'b0;
        bus.wbTagA_i        = '0;
        bus.wbDataA_i       = 64'd0;
        bus.wbFlagValidA_i  = 1'b0;
        bus.wbFlagsA_i      = 4'd0;
        bus.wbValidB_i      = 1'b0;
        bus.wbTagB_i        = '0;
        bus.wbDataB_i       = 64'd0;
        bus.readTag_i       = '0;
        bus.ROBupdateHead_i = 1'b0;
        bus.flush_i         = 1'b0;
    endtask

    // Inputs are set just after a negedge; outputs checked, then the edge applied to both.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic alloc(input logic [3:0] cmd, input logic [4:0] rd, input logic [63:0] data);
        idle();
        bus.allocValid_i   = 1'b1;
        bus.allocCmdType_i = cmd;
        bus.allocRD_i      = rd;
        bus.allocData_i    = data;
        tick();
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("rst_allocTag", 79'(bus.allocTag_o), 79'd1);
        chk("rst_head", 79'(bus.ROBhead_o), 79'd1);
        chk("rst_full", 79'(bus.full_o), 79'd0);
        chk("rst_commit", bus.ROBcommitReadData_o, 79'd0);
        chk("rst_readReady", 79'(bus.readReady_o), 79'd0);

        for (int r = 1; r <= 3; r++) begin
            chk("alloc_seq", 79'(bus.allocTag_o), 79'(r));
            alloc(4'd0, 5'(r), 64'd0);
        end
        idle();
        #1;
        chk("three_head", 79'(bus.ROBhead_o), 79'd1);
        chk("three_notdone", 79'(bus.ROBcommitReadData_o[64]), 79'd0);

        bus.wbValidA_i = 1'b1; bus.wbTagA_i = TW'(1); bus.wbDataA_i = 64'h2A;
        bus.wbFlagValidA_i = 1'b1; bus.wbFlagsA_i = 4'b0010;
        tick();
        idle();
        #1;
        chk("wb_commit_word", bus.ROBcommitReadData_o, {4'd0, 5'd1, 1'b1, 4'b0010, 1'b1, 64'h2A});
        bus.ROBupdateHead_i = 1'b1;
        tick();
        idle();
        #1;
        chk("retire_head", 79'(bus.ROBhead_o), 79'd2);

        bus.flush_i = 1'b1;
        tick();
        for (int i = 0; i < N; i++) alloc(4'($urandom_range(0, 9)), 5'($urandom), {$urandom, $urandom});
        idle();
        #1;
        chk("fill_full", 79'(bus.full_o), 79'd1);
        alloc(4'd9, 5'd7, 64'd0);
        chk("drop_tag", 79'(bus.allocTag_o), 79'd1);
        bus.wbValidB_i = 1'b1; bus.wbTagB_i = TW'(1); bus.wbDataB_i = 64'h77;
        tick();
        idle();
        bus.ROBupdateHead_i = 1'b1;
        bus.allocValid_i    = 1'b1;
        tick();
        idle();
        #1;
        chk("retire_frees", 79'(bus.full_o), 79'd0);
        chk("retire_head2", 79'(bus.ROBhead_o), 79'd2);
        alloc(4'd1, 5'd3, 64'd0);
        chk("wrap_full", 79'(bus.full_o), 79'd1);
        chk("wrap_tag", 79'(bus.allocTag_o), 79'd2);

        idle();
        bus.flush_i = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) alloc(4'd0, 5'(i), 64'd0);
        idle();
        bus.wbValidA_i = 1'b1; bus.wbTagA_i = TW'(5); bus.wbDataA_i = 64'h11;
        bus.wbValidB_i = 1'b1; bus.wbTagB_i = TW'(5); bus.wbDataB_i = 64'h22;
        tick();
        idle();
        bus.wbValidB_i = 1'b1; bus.wbTagB_i = TW'(9); bus.wbDataB_i = 64'hFF;
        tick();
        idle();
        bus.readTag_i = TW'(5);
        #1;
        chk("ab_ready", 79'(bus.readReady_o), 79'd1);
        chk("ab_data", 79'(bus.readData_o), 79'h11);
        bus.readTag_i = TW'(9);
        #1;
        chk("unocc_ready", 79'(bus.readReady_o), 79'd0);
        chk("unocc_data", 79'(bus.readData_o), 79'd0);

        idle();
        bus.flush_i = 1'b1; bus.allocValid_i = 1'b1;
        bus.wbValidA_i = 1'b1; bus.wbTagA_i = TW'(2); bus.wbDataA_i = 64'h5;
        tick();
        idle();
        #1;
        chk("flush_full", 79'(bus.full_o), 79'd0);
        chk("flush_head", 79'(bus.ROBhead_o), 79'd1);
        chk("flush_tail", 79'(bus.allocTag_o), 79'd1);
        chk("flush_commit", bus.ROBcommitReadData_o, 79'd0);

        for (int i = 0; i < 4; i++) alloc(4'd0, 5'(i), 64'(i + 1));
        idle();
        bus.wbValidA_i = 1'b1; bus.wbTagA_i = TW'(1); bus.wbDataA_i = 64'h9;
        tick();
        idle();
        bus.allocValid_i = 1'b1;
        bus.readTag_i    = TW'(1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_allocTag", 79'(bus.allocTag_o), 79'd1);
        chk("async_head", 79'(bus.ROBhead_o), 79'd1);
        chk("async_commit", bus.ROBcommitReadData_o, 79'd0);
        chk("async_readReady", 79'(bus.readReady_o), 79'd0);
        chk("async_readData", 79'(bus.readData_o), 79'd0);
        rob.delete();
        tail = 1;
        @(negedge clk_i);
        reset_i = 1'b0;
        idle();

        for (int c = 0; c < 3000; c++) begin
            idle();
            bus.allocValid_i    = 1'($urandom_range(0, 9) < 6);
            bus.allocCmdType_i  = 4'($urandom_range(0, 9));
            bus.allocRD_i       = 5'($urandom);
            bus.allocData_i     = {$urandom, $urandom};
            bus.wbValidA_i      = 1'($urandom_range(0, 1));
            bus.wbTagA_i        = pick_tag();
            bus.wbDataA_i       = {$urandom, $urandom};
            bus.wbFlagValidA_i  = 1'($urandom_range(0, 1));
            bus.wbFlagsA_i      = 4'($urandom);
            bus.wbValidB_i      = 1'($urandom_range(0, 1));
            bus.wbTagB_i        = pick_tag();
            bus.wbDataB_i       = {$urandom, $urandom};
            bus.readTag_i       = pick_tag();
            bus.ROBupdateHead_i = 1'($urandom_range(0, 2) != 0);
            bus.flush_i         = 1'($urandom_range(0, 99) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

`default_nettype wire
